wide_addsub_seq: RTL and testbench
==================================

Name: wide_addsub_seq

Overview:
Multi-precision add/subtract sequencer built around one instance of the team's 32-bit carry-lookahead adder, CLA_adder (a, b, Cin, sum, Cout, of). It accepts a WORDS-limb operation one 32-bit limb pair per cycle, least-significant limb first, and chains the carry between limbs. Each limb result streams out through a valid/ready port. Final carry and signed overflow are reported at the end of the operation.

Parameters:
WIDTH, 32, limb width; fixed to match CLA_adder. Elaboration error if not 32.
WORDS, 4, limbs per operation; legal range 1..256.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin an operation; sampled only in IDLE
sub  in  1  captured with start: 0 = A+B, 1 = A-B
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the last result limb is consumed
in_valid  in  1  limb pair present
in_ready  out  1  limb pair accepted this cycle when in_valid is also high
in_a  in  WIDTH  operand A limb
in_b  in  WIDTH  operand B limb
out_valid  out  1  result limb present
out_ready  in  1  consumer accepts the result limb
out_sum  out  WIDTH  result limb
out_last  out  1  marks the most-significant result limb
cout  out  1  final carry; for subtract, 1 = no borrow
of  out  1  signed overflow of the full-width result

Behaviour:
- Reset (async): state = IDLE. busy, done, in_ready, out_valid, out_last, cout, of = 0. out_sum = 0. Limb count = 0. Carry register = 0. Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready = 0.
  - On start: capture sub into sub_r; carry_r = sub; cnt = 0; clear cout and of; go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready (no skid buffer).
  - Adder inputs: a = in_a, b = in_b XOR {WIDTH{sub_r}}, Cin = carry_r.
  - Accept when in_valid && in_ready. On accept: out_sum <= adder sum; out_valid <= 1; out_last <= (cnt == WORDS-1); carry_r <= adder Cout; cnt++.
  - Accept of the last limb: cout <= adder Cout; of <= adder of; go to DRAIN.
  - Non-last limbs never update cout or of.
- DRAIN:
  - in_ready = 0.
  - When out_valid && out_ready: out_valid <= 0, out_last <= 0, done pulses for 1 cycle, busy <= 0, go to IDLE.
- Output register:
  - If out_valid && out_ready and no new accept in the same cycle, out_valid <= 0.
  - While out_valid && !out_ready, out_sum and out_last are held stable.
- Latency and throughput: a limb accepted at edge N appears as out_valid at N+1. Throughput is 1 limb per cycle while out_ready = 1.
- Flag lifetime: cout and of stay valid from the last-limb accept until the next start.
- start while busy is ignored. in_valid outside RUN is ignored (in_ready = 0).
- WORDS = 1: the block behaves as a registered single adder.
- Counter width: clog2(WORDS) bits, minimum 1.
- Subtract uses two's complement: invert B, initial carry = 1.

Decomposition:
- Shared package: state enum (IDLE, RUN, DRAIN) and a helper that computes the counter width from WORDS.
- One sub-module: the existing CLA_adder, instantiated once and driven combinationally from the RUN datapath. No other hierarchy.

Test Plan:
1. WORDS=1, add, limb 7fffffff + 7fffffff -> out_sum fffffffe, out_last 1, cout 0, of 1, done pulse 1 cycle.
2. WORDS=2, add, A = 00000000_ffffffff, B = 00000000_00000001, out_ready = 1 -> limbs 00000000 then 00000001 on consecutive cycles; cout 0, of 0.
3. WORDS=2, sub, A = 00000001_00000000, B = 00000000_00000001 -> limbs ffffffff then 00000000; cout 1, of 0.
4. Backpressure: WORDS=4, out_ready held 0 for 3 cycles after the first result -> in_ready 0, out_sum stable, carry preserved; the remaining 3 limbs are correct after release.
5. Reset asserted after 2 of 4 limbs -> all outputs 0 immediately, no done pulse; a new start then completes correctly.
6. start pulsed during RUN -> ignored, sub_r unchanged; exactly one done pulse per operation.

Source files
------------

// File: rtl/wide_addsub_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
// Holds the sequencer state encoding and the limb-counter sizing rule.
package wide_addsub_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Limb counter needs at least one bit even for single-limb operations.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/wide_addsub_seq_if.sv
// Control, limb input stream and limb result stream of the add/subtract sequencer.
// The sequencer itself connects through the slave modport.
interface wide_addsub_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sub;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_last;
    logic             cout;
    logic             of;

    modport master (
        output start, sub, in_valid, in_a, in_b, out_ready,
        input  busy, done, in_ready, out_valid, out_sum, out_last, cout, of
    );

    modport slave (
        input  start, sub, in_valid, in_a, in_b, out_ready,
        output busy, done, in_ready, out_valid, out_sum, out_last, cout, of
    );
endinterface

// File: rtl/wide_addsub_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
// of is the signed overflow of the 32-bit result.
module CLA_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        Cin,
    output logic [31:0] sum,
    output logic        Cout,
    output logic        of
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [8:0]  bc;
    logic [7:0]  gg;
    logic [7:0]  gp;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        bc = '0;
        gg = '0;
        gp = '0;
        bc[0] = Cin;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            bc[k+1] = gg[k] | (gp[k] & bc[k]);
            c[4*k] = bc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[32] = bc[8];
    end

    assign sum  = p ^ c[31:0];
    assign Cout = c[32];
    assign of   = c[32] ^ c[31];

endmodule

// File: rtl/wide_addsub_seq.sv
// Multi-precision add/subtract sequencer: one limb pair per cycle, LS limb first, carry
// chained through a single CLA_adder; results stream out through a registered valid/ready port.
module wide_addsub_seq
    import wide_addsub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 4
) (
    input logic              clk,
    input logic              rst,
    wide_addsub_seq_if.slave bus
);

    if (WIDTH != 32) begin : g_width_chk
        $error("wide_addsub_seq: WIDTH must be 32 to match CLA_adder");
    end
    if (WORDS < 1 || WORDS > 256) begin : g_words_chk
        $error("wide_addsub_seq: WORDS must be in 1..256");
    end

    localparam int unsigned CW = cnt_width(WORDS);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LastCnt = cnt_t'(WORDS - 1);

    state_e           state_q, state_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    cnt_t             cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             last_q, last_d;
    logic             cout_q, cout_d;
    logic             of_q, of_d;
    logic             in_ready_c;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_of;

    // Subtract is A + ~B + 1; the +1 enters through the initial carry.
    CLA_adder u_cla (
        .a   (bus.in_a),
        .b   (bus.in_b ^ {WIDTH{sub_q}}),
        .Cin (carry_q),
        .sum (add_sum),
        .Cout(add_cout),
        .of  (add_of)
    );

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ov_d       = ov_q;
        sum_d      = sum_q;
        last_d     = last_q;
        cout_d     = cout_q;
        of_d       = of_q;
        in_ready_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    of_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // No skid buffer: a new limb only enters when the result register frees up.
                in_ready_c = !ov_q || bus.out_ready;
                if (ov_q && bus.out_ready) begin
                    ov_d   = 1'b0;
                    last_d = 1'b0;
                end
                if (bus.in_valid && in_ready_c) begin
                    sum_d   = add_sum;
                    ov_d    = 1'b1;
                    last_d  = (cnt_q == LastCnt);
                    carry_d = add_cout;
                    cnt_d   = cnt_t'(cnt_q + 1'b1);
                    if (cnt_q == LastCnt) begin
                        cout_d  = add_cout;
                        of_d    = add_of;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (ov_q && bus.out_ready) begin
                    ov_d    = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = ov_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_last  = last_q;
    assign bus.cout      = cout_q;
    assign bus.of        = of_q;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Bench for wide_addsub_seq: three instances (WORDS = 1, 2, 4) against a big-integer model,
// directed cases pinned with literal results, then randomized operands, stalls and reset.
module tb_wide_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       start_s = '0, sub_s = '0, in_valid_s = '0, out_ready_s = '0;
    logic [2:0][31:0] in_a_s = '0, in_b_s = '0;
    logic [2:0]       busy_s, done_s, in_ready_s, out_valid_s, out_last_s, cout_s, of_s;
    logic [2:0][31:0] out_sum_s;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        wide_addsub_seq_if #(.WIDTH(32)) u_if ();
        assign u_if.start     = start_s[g];
        assign u_if.sub       = sub_s[g];
        assign u_if.in_valid  = in_valid_s[g];
        assign u_if.in_a      = in_a_s[g];
        assign u_if.in_b      = in_b_s[g];
        assign u_if.out_ready = out_ready_s[g];
        assign busy_s[g]      = u_if.busy;
        assign done_s[g]      = u_if.done;
        assign in_ready_s[g]  = u_if.in_ready;
        assign out_valid_s[g] = u_if.out_valid;
        assign out_sum_s[g]   = u_if.out_sum;
        assign out_last_s[g]  = u_if.out_last;
        assign cout_s[g]      = u_if.cout;
        assign of_s[g]        = u_if.of;
        wide_addsub_seq #(.WIDTH(32), .WORDS(W)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(u_if)
        );
    end

    int words_of [3] = '{1, 2, 4};

    // Model results for the operation currently issued on each instance.
    logic [31:0] exp_sum [3][4];
    logic [2:0]  exp_cout = '0, exp_of = '0;
    // Hand-computed results for directed cases.
    logic [2:0]  lit_on = '0, lit_cout = '0, lit_of = '0;
    logic [31:0] lit_sum [3][4];

    int vectors = 0;
    int miscompares = 0;
    int tmo_cnt = 0;
    int tmo_seen = 0;

    function automatic void model(input int d, input logic s, input logic [127:0] a,
                                  input logic [127:0] b);
        int nb;
        logic [127:0] mask, am, bm;
        logic [128:0] r;
        nb   = 32 * words_of[d];
        mask = (nb == 128) ? '1 : ((128'd1 << nb) - 128'd1);
        am   = a & mask;
        bm   = b & mask;
        if (!s) begin
            r = {1'b0, am} + {1'b0, bm};
            exp_cout[d] = r[nb];
            exp_of[d]   = (am[nb-1] == bm[nb-1]) && (r[nb-1] != am[nb-1]);
        end else begin
            r = {1'b0, am} - {1'b0, bm};
            exp_cout[d] = (am >= bm);
            exp_of[d]   = (am[nb-1] != bm[nb-1]) && (r[nb-1] != am[nb-1]);
        end
        for (int i = 0; i < 4; i++) exp_sum[d][i] = r[i*32 +: 32];
    endfunction

    task automatic chk(input string nm, input int d, input logic [32:0] got,
                       input logic [32:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, required %h", nm, d, got, req);
        end
    endtask

    // Compare process: spec-level expectations, updated from what each edge will sample.
    logic [2:0]  m_busy = '0, m_done = '0, m_ov = '0, m_hold = '0, m_cout = '0, m_of = '0;
    int          m_acc [3] = '{0, 0, 0};
    int          m_idx [3] = '{0, 0, 0};
    logic [32:0] held [3];

    always @(negedge clk) begin
        logic nd;
        logic exp_ir;
        if (tmo_cnt != tmo_seen) begin
            miscompares += tmo_cnt - tmo_seen;
            tmo_seen = tmo_cnt;
        end
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                chk("reset_ctl", d, 33'({busy_s[d], done_s[d], in_ready_s[d], out_valid_s[d],
                                         out_last_s[d], cout_s[d], of_s[d]}), 33'd0);
                chk("reset_sum", d, 33'(out_sum_s[d]), 33'd0);
                m_busy[d] = 0; m_done[d] = 0; m_ov[d] = 0; m_hold[d] = 0;
                m_cout[d] = 0; m_of[d] = 0; m_acc[d] = 0; m_idx[d] = 0;
            end else begin
                chk("done", d, 33'(done_s[d]), 33'(m_done[d]));
                chk("busy", d, 33'(busy_s[d]), 33'(m_busy[d]));
                chk("cout", d, 33'(cout_s[d]), 33'(m_cout[d]));
                chk("of", d, 33'(of_s[d]), 33'(m_of[d]));
                if (m_done[d] && lit_on[d]) begin
                    chk("lit_cout", d, 33'(cout_s[d]), 33'(lit_cout[d]));
                    chk("lit_of", d, 33'(of_s[d]), 33'(lit_of[d]));
                end
                if (m_ov[d]) chk("out_valid_latency", d, 33'(out_valid_s[d]), 33'd1);
                exp_ir = m_busy[d] && (m_acc[d] < words_of[d])
                         && (!out_valid_s[d] || out_ready_s[d]);
                chk("in_ready", d, 33'(in_ready_s[d]), 33'(exp_ir));
                if (m_hold[d] && out_valid_s[d])
                    chk("hold_stable", d, {out_last_s[d], out_sum_s[d]}, held[d]);

                nd = 1'b0;
                if (out_valid_s[d] && out_ready_s[d]) begin
                    if (m_idx[d] < words_of[d]) begin
                        chk("limb", d, {out_last_s[d], out_sum_s[d]},
                            {(m_idx[d] == words_of[d] - 1), exp_sum[d][m_idx[d]]});
                        if (lit_on[d])
                            chk("lit_limb", d, 33'(out_sum_s[d]), 33'(lit_sum[d][m_idx[d]]));
                        nd = (m_idx[d] == words_of[d] - 1);
                    end else begin
                        chk("extra_limb", d, 33'(out_valid_s[d]), 33'd0);
                    end
                    m_idx[d]++;
                end
                m_hold[d] = out_valid_s[d] && !out_ready_s[d];
                held[d]   = {out_last_s[d], out_sum_s[d]};
                m_ov[d]   = in_valid_s[d] && in_ready_s[d];
                if (in_valid_s[d] && in_ready_s[d]) begin
                    m_acc[d]++;
                    if (m_acc[d] == words_of[d]) begin
                        m_cout[d] = exp_cout[d];
                        m_of[d]   = exp_of[d];
                    end
                end
                if (!m_busy[d] && start_s[d]) begin
                    m_busy[d] = 1'b1; m_acc[d] = 0; m_idx[d] = 0;
                    m_cout[d] = 1'b0; m_of[d] = 1'b0;
                end else if (nd) begin
                    m_busy[d] = 1'b0;
                end
                m_done[d] = nd;
            end
        end
    end

    task automatic run_op(input int d, input logic s, input logic [127:0] a,
                          input logic [127:0] b, input int vprob, input int rprob,
                          input bit stall, input bit restart, input int abort_at);
        int n, k, cyc, stall_left;
        bit stalled, fin;
        n = words_of[d]; k = 0; cyc = 0; stall_left = 0; stalled = 0; fin = 0;
        model(d, s, a, b);
        @(posedge clk); #1;
        start_s[d] = 1'b1; sub_s[d] = s;
        @(posedge clk); #1;
        start_s[d] = 1'b0; sub_s[d] = ~s;
        while (!fin) begin
            if (stall && !stalled && out_valid_s[d]) begin
                stall_left = 3; stalled = 1;
            end
            in_valid_s[d] = (k < n) && ($urandom_range(99) < vprob);
            in_a_s[d] = (k < n) ? a[k*32 +: 32] : $urandom;
            in_b_s[d] = (k < n) ? b[k*32 +: 32] : $urandom;
            if (stall_left > 0) begin
                out_ready_s[d] = 1'b0;
                stall_left--;
            end else begin
                out_ready_s[d] = stall || ($urandom_range(99) < rprob);
            end
            start_s[d] = restart && (k == 1);
            @(negedge clk);
            if (in_valid_s[d] && in_ready_s[d]) k++;
            @(posedge clk); #1;
            cyc++;
            if (abort_at > 0 && k == abort_at) begin
                #2 rst = 1'b1;
                in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0; start_s[d] = 1'b0;
                repeat (2) @(negedge clk);
                @(posedge clk); #1 rst = 1'b0;
                fin = 1;
            end else if (done_s[d]) begin
                fin = 1;
            end else if (cyc > 300) begin
                tmo_cnt++;
                $display("FAIL timeout dut%0d: got no done after %0d cycles, required done", d,
                         cyc);
                fin = 1;
            end
        end
        in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0; start_s[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int d;
        logic [127:0] a, b;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single-limb add with signed overflow.
        lit_on = 3'b001; lit_sum[0][0] = 32'hffff_fffe; lit_cout[0] = 0; lit_of[0] = 1;
        run_op(0, 1'b0, 128'h7fff_ffff, 128'h7fff_ffff, 100, 100, 0, 0, 0);
        // Two-limb add with carry into the upper limb.
        lit_on = 3'b010; lit_sum[1][0] = 32'h0; lit_sum[1][1] = 32'h1;
        lit_cout[1] = 0; lit_of[1] = 0;
        run_op(1, 1'b0, 128'h0000_0000_ffff_ffff, 128'h1, 100, 100, 0, 0, 0);
        // Two-limb subtract with borrow out of the lower limb.
        lit_sum[1][0] = 32'hffff_ffff; lit_sum[1][1] = 32'h0; lit_cout[1] = 1; lit_of[1] = 0;
        run_op(1, 1'b1, 128'h0000_0001_0000_0000, 128'h1, 100, 100, 0, 0, 0);
        lit_on = '0;

        // Backpressure after the first result.
        run_op(2, 1'b0, {$urandom, $urandom, 32'hffff_ffff, 32'hffff_ffff},
               {$urandom, $urandom, 32'h0, 32'h1}, 100, 100, 1, 0, 0);
        // Reset after two limbs, then a clean operation.
        run_op(2, 1'b1, {4{$urandom}}, {4{$urandom}}, 100, 100, 0, 0, 2);
        run_op(2, 1'b1, {$urandom, $urandom, $urandom, $urandom}, {4{32'h8000_0000}},
               100, 100, 0, 0, 0);
        // start pulsed mid-operation must be ignored.
        run_op(2, 1'b0, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 100, 100, 0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            d = $urandom_range(2);
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(3))
                0: b = a;
                1: b = ~a;
                default: ;
            endcase
            run_op(d, 1'($urandom_range(1)), a, b, 40 + $urandom_range(60),
                   30 + $urandom_range(70), 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
